// File: rtl/ram_sdp_param.sv
// ram_sdp_param -- parametrised single-clock simple-dual-port RAM model.
//
// One write port with per-lane enables, one read port with an optional
// read-address register and an optional read-data register. Each register
// has an enable and an active-low synchronous load of a replicated bit. When
// a read and an accepted write hit the same word, the read returns either
// the pre-write contents or the merged new contents. A registered flag
// reports that such a collision happened on the previous edge.
//
// The storage is split into NLANES lane slices (ram_sdp_lane). Each slice
// holds LANE_W bits of every word and carries its own write enable and its
// own collision forwarding.
//
// Ports (ram_sdp_param):
//   clk          single clock, rising edge
//   rst_n        async active-low reset. It clears the pipeline registers and
//                the collision flag. It never clears the array.
//   r_addr       read address
//   r_addr_en    read-address register enable
//   r_addr_sl_n  read-address sync load (active low), loads {AW{r_addr_sd}}
//   r_addr_sd    read-address sync-load bit
//   blk_en       read-port block enable; 0 forces the array read value to 0
//   r_data       read data
//   r_data_en    read-data register enable
//   r_data_sl_n  read-data sync load (active low), loads {WIDTH{r_data_sd}}
//   r_data_sd    read-data sync-load bit
//   w_addr       write address; writes at or above DEPTH are dropped
//   w_data       write data
//   w_en         write request
//   w_be         per-lane write enable
//   busy_fb      write throttle; high blocks the write on this edge
//   access_busy  registered collision flag

// One LANE_W-bit slice of every word, plus its read mux.
module ram_sdp_lane #(
  parameter int              LANE_W = 12,
  parameter int              DEPTH  = 64,
  parameter int              AW     = 6,
  parameter logic [LANE_W-1:0] INIT = '0,
  parameter bit              FWD    = 1'b0   // 1 = write-through on collision
) (
  input  logic              clk,
  input  logic              we,       // accepted write AND this lane's enable
  input  logic [AW-1:0]     w_addr,
  input  logic [LANE_W-1:0] w_data,
  input  logic              rd_ok,    // block enabled and address in range
  input  logic [AW-1:0]     ra,
  input  logic              coll,     // accepted write to the word being read
  output logic [LANE_W-1:0] rv
);
  // The contents hold INIT from time zero. Reset never touches them.
  logic [LANE_W-1:0] mem [DEPTH] = '{default: INIT};

  always_ff @(posedge clk)
    if (we) mem[w_addr] <= w_data;

  // The array read is asynchronous, so it shows the pre-write contents until
  // the edge. Write-through only swaps in this lane's data when this lane is
  // actually being written.
  always_comb begin
    rv = '0;
    if (rd_ok) rv = (FWD && coll && we) ? w_data : mem[ra];
  end
endmodule

module ram_sdp_param #(
  parameter int               WIDTH          = 12,
  parameter int               DEPTH          = 64,
  parameter int               LANE_W         = 12,
  parameter int               RD_ADDR_REG    = 1,
  parameter int               RD_DATA_REG    = 1,
  parameter int               COLLISION_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL       = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(DEPTH)-1:0]   r_addr,
  input  logic                       r_addr_en,
  input  logic                       r_addr_sl_n,
  input  logic                       r_addr_sd,
  input  logic                       blk_en,
  output logic [WIDTH-1:0]           r_data,
  input  logic                       r_data_en,
  input  logic                       r_data_sl_n,
  input  logic                       r_data_sd,
  input  logic [$clog2(DEPTH)-1:0]   w_addr,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       w_en,
  input  logic [WIDTH/LANE_W-1:0]    w_be,
  input  logic                       busy_fb,
  output logic                       access_busy
);
  localparam int             AW      = $clog2(DEPTH);
  localparam int             NLANES  = WIDTH / LANE_W;
  // One bit wider than an address, so a non-power-of-two DEPTH compares cleanly.
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic                          vld;
    logic [AW-1:0]                 addr;
    logic [NLANES-1:0][LANE_W-1:0] data;
    logic [NLANES-1:0]             be;
  } wr_req_t;

  wr_req_t                       wr;
  logic [AW-1:0]                 ra;
  logic                          rd_ok;
  logic                          coll;
  logic [NLANES-1:0][LANE_W-1:0] rv;

  // The write is accepted whether or not reset is asserted.
  assign wr.vld  = w_en & ~busy_fb & ({1'b0, w_addr} < DEPTH_C);
  assign wr.addr = w_addr;
  assign wr.data = w_data;
  assign wr.be   = w_be;

  // Read-address stage.
  if (RD_ADDR_REG != 0) begin : g_areg
    logic [AW-1:0] areg;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)            areg <= '0;
      else if (!r_addr_sl_n) areg <= {AW{r_addr_sd}};
      else if (r_addr_en)    areg <= r_addr;
    assign ra = areg;
  end else begin : g_abyp
    logic unused_areg;
    assign unused_areg = ^{r_addr_en, r_addr_sl_n, r_addr_sd};
    assign ra = r_addr;
  end

  assign rd_ok = blk_en & ({1'b0, ra} < DEPTH_C);
  // wr.vld already implies an in-range address, so ra matching it is in range too.
  assign coll  = wr.vld & blk_en & (ra == wr.addr);

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    ram_sdp_lane #(
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .INIT   (INIT_VAL[l*LANE_W +: LANE_W]),
      .FWD    (COLLISION_MODE == 1)
    ) u_lane (
      .clk    (clk),
      .we     (wr.vld & wr.be[l]),
      .w_addr (wr.addr),
      .w_data (wr.data[l]),
      .rd_ok  (rd_ok),
      .ra     (ra),
      .coll   (coll),
      .rv     (rv[l])
    );
  end

  // Read-data stage. Collision semantics only matter here, where rv is
  // captured on the same edge as the write.
  if (RD_DATA_REG != 0) begin : g_dreg
    logic [WIDTH-1:0] dreg;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)            dreg <= '0;
      else if (!r_data_sl_n) dreg <= {WIDTH{r_data_sd}};
      else if (r_data_en)    dreg <= rv;
    assign r_data = dreg;
  end else begin : g_dbyp
    logic unused_dreg;
    assign unused_dreg = ^{r_data_en, r_data_sl_n, r_data_sd};
    assign r_data = rv;
  end

  // The flag is evaluated in both modes. It is high for exactly the cycle
  // after each collision edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) access_busy <= 1'b0;
    else        access_busy <= coll;
endmodule

// File: tb/tb_ram_sdp_param.sv
// Testbench for ram_sdp_param. Five configurations share one stimulus stream:
//   u0 default 12x64, both regs, read-old-data
//   u1 24-bit, 8-bit lanes, DEPTH=48, both regs, write-through, non-zero init
//   u2 no address reg, data reg, read-old-data
//   u3 no address reg, data reg, write-through
//   u4 no registers (combinational read), write-through, non-zero init
// A per-instance reference model (array plus register values) predicts every
// output each cycle. Directed checks against literal values cover the listed scenarios.
module tb_ram_sdp_param;
  localparam int NK = 5;
  localparam int C_W    [NK] = '{12, 24, 12, 12, 12};
  localparam int C_L    [NK] = '{12,  8, 12, 12, 12};
  localparam int C_D    [NK] = '{64, 48, 64, 64, 64};
  localparam int C_RA   [NK] = '{ 1,  1,  0,  0,  0};
  localparam int C_RD   [NK] = '{ 1,  1,  1,  1,  0};
  localparam int C_MODE [NK] = '{ 0,  1,  0,  1,  1};
  localparam logic [23:0] C_INIT [NK] = '{24'h0, 24'h5A5A5A, 24'h0, 24'h0, 24'h3C3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [5:0]  r_addr, w_addr;
  logic        r_addr_en, r_addr_sl_n, r_addr_sd, blk_en;
  logic        r_data_en, r_data_sl_n, r_data_sd;
  logic [23:0] w_data;
  logic        w_en, busy_fb;
  logic [2:0]  w_be;

  logic [11:0] rd0, rd2, rd3, rd4;
  logic [23:0] rd1;
  logic [NK-1:0] bz;
  logic [23:0] got_rd [NK];

  assign got_rd[0] = {12'h0, rd0};
  assign got_rd[1] = rd1;
  assign got_rd[2] = {12'h0, rd2};
  assign got_rd[3] = {12'h0, rd3};
  assign got_rd[4] = {12'h0, rd4};

  ram_sdp_param u0 (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_addr_en(r_addr_en),
    .r_addr_sl_n(r_addr_sl_n), .r_addr_sd(r_addr_sd), .blk_en(blk_en),
    .r_data(rd0), .r_data_en(r_data_en), .r_data_sl_n(r_data_sl_n),
    .r_data_sd(r_data_sd), .w_addr(w_addr), .w_data(w_data[11:0]),
    .w_en(w_en), .w_be(w_be[0:0]), .busy_fb(busy_fb), .access_busy(bz[0]));

  ram_sdp_param #(.WIDTH(24), .DEPTH(48), .LANE_W(8), .COLLISION_MODE(1),
                  .INIT_VAL(24'h5A5A5A)) u1 (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_addr_en(r_addr_en),
    .r_addr_sl_n(r_addr_sl_n), .r_addr_sd(r_addr_sd), .blk_en(blk_en),
    .r_data(rd1), .r_data_en(r_data_en), .r_data_sl_n(r_data_sl_n),
    .r_data_sd(r_data_sd), .w_addr(w_addr), .w_data(w_data),
    .w_en(w_en), .w_be(w_be), .busy_fb(busy_fb), .access_busy(bz[1]));

  ram_sdp_param #(.RD_ADDR_REG(0), .COLLISION_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_addr_en(r_addr_en),
    .r_addr_sl_n(r_addr_sl_n), .r_addr_sd(r_addr_sd), .blk_en(blk_en),
    .r_data(rd2), .r_data_en(r_data_en), .r_data_sl_n(r_data_sl_n),
    .r_data_sd(r_data_sd), .w_addr(w_addr), .w_data(w_data[11:0]),
    .w_en(w_en), .w_be(w_be[0:0]), .busy_fb(busy_fb), .access_busy(bz[2]));

  ram_sdp_param #(.RD_ADDR_REG(0), .COLLISION_MODE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_addr_en(r_addr_en),
    .r_addr_sl_n(r_addr_sl_n), .r_addr_sd(r_addr_sd), .blk_en(blk_en),
    .r_data(rd3), .r_data_en(r_data_en), .r_data_sl_n(r_data_sl_n),
    .r_data_sd(r_data_sd), .w_addr(w_addr), .w_data(w_data[11:0]),
    .w_en(w_en), .w_be(w_be[0:0]), .busy_fb(busy_fb), .access_busy(bz[3]));

  ram_sdp_param #(.RD_ADDR_REG(0), .RD_DATA_REG(0), .COLLISION_MODE(1),
                  .INIT_VAL(12'h3C3)) u4 (
    .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_addr_en(r_addr_en),
    .r_addr_sl_n(r_addr_sl_n), .r_addr_sd(r_addr_sd), .blk_en(blk_en),
    .r_data(rd4), .r_data_en(r_data_en), .r_data_sl_n(r_data_sl_n),
    .r_data_sd(r_data_sd), .w_addr(w_addr), .w_data(w_data[11:0]),
    .w_en(w_en), .w_be(w_be[0:0]), .busy_fb(busy_fb), .access_busy(bz[4]));

  // ---------------- reference model ----------------
  logic [23:0] mem_m  [NK][64];
  logic [5:0]  areg_m [NK];
  logic [23:0] dreg_m [NK];
  logic        bz_m   [NK];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] wmask(int k);
    return 24'((32'd1 << C_W[k]) - 1);
  endfunction

  // Bit mask of the lanes enabled by w_be for instance k.
  function automatic logic [23:0] be_mask(int k);
    logic [23:0] m;
    m = '0;
    for (int l = 0; l < C_W[k] / C_L[k]; l++)
      if (w_be[l]) m = m | 24'(((32'd1 << C_L[k]) - 1) << (l * C_L[k]));
    return m;
  endfunction

  function automatic logic [5:0] ra_m(int k);
    return (C_RA[k] != 0) ? areg_m[k] : r_addr;
  endfunction

  function automatic logic wacc_m(int k);
    return w_en && !busy_fb && (int'(w_addr) < C_D[k]);
  endfunction

  function automatic logic coll_m(int k);
    return wacc_m(k) && blk_en && (ra_m(k) == w_addr);
  endfunction

  function automatic logic [23:0] rv_m(int k);
    logic [5:0]  ra;
    logic [23:0] v, m;
    ra = ra_m(k);
    if (!blk_en || int'(ra) >= C_D[k]) return 24'h0;
    v = mem_m[k][ra];
    if (C_MODE[k] == 1 && coll_m(k)) begin
      m = be_mask(k);
      v = (v & ~m) | (w_data & m);
    end
    return v;
  endfunction

  // Applies one rising edge to every model instance.
  task automatic model_step();
    for (int k = 0; k < NK; k++) begin
      logic [23:0] v, m;
      logic        c, wa;
      v  = rv_m(k);
      c  = coll_m(k);
      wa = wacc_m(k);
      if (wa) begin
        m = be_mask(k);
        mem_m[k][w_addr] = (mem_m[k][w_addr] & ~m) | (w_data & m);
      end
      if (rst_n) begin
        if (!r_addr_sl_n)   areg_m[k] = {6{r_addr_sd}};
        else if (r_addr_en) areg_m[k] = r_addr;
        if (!r_data_sl_n)   dreg_m[k] = r_data_sd ? wmask(k) : 24'h0;
        else if (r_data_en) dreg_m[k] = v;
        bz_m[k] = c;
      end
    end
  endtask

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v)
      for (int k = 0; k < NK; k++) begin
        areg_m[k] = '0;
        dreg_m[k] = '0;
        bz_m[k]   = 1'b0;
      end
  endtask

  task automatic check_all();
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("u%0d.r_data", k), got_rd[k], (C_RD[k] != 0) ? dreg_m[k] : rv_m(k));
      chk($sformatf("u%0d.access_busy", k), {23'h0, bz[k]}, {23'h0, bz_m[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    w_en = 0; busy_fb = 0; w_addr = 0; w_data = 0; w_be = 3'b111;
    r_addr = 0; r_addr_en = 1; r_addr_sl_n = 1; r_addr_sd = 0; blk_en = 1;
    r_data_en = 1; r_data_sl_n = 1; r_data_sd = 0;
  endtask

  initial begin
    for (int k = 0; k < NK; k++)
      for (int a = 0; a < 64; a++) mem_m[k][a] = C_INIT[k];
    idle();
    set_rst(1'b0);
    tick(); tick();
    chk("reset_r_data", got_rd[0], 24'h0);
    chk("reset_busy", {23'h0, bz[0]}, 24'h0);
    set_rst(1'b1);

    // Two-edge read latency on the default configuration.
    w_en = 1; w_addr = 5; w_data = 24'h000ABC; tick();
    w_en = 0; r_addr = 5; tick();
    chk("rd5_after_1_edge", got_rd[0], 24'h0);
    tick();
    chk("rd5_after_2_edges", got_rd[0], 24'hABC);
    r_addr = 6; tick(); tick();
    chk("rd6_init", got_rd[0], 24'h0);
    chk("u4_comb_init", got_rd[4], 24'h3C3);

    // Lane-masked write on the 24-bit instance.
    w_en = 1; w_addr = 3; w_data = 24'h112233; w_be = 3'b111; tick();
    w_data = 24'hAABBCC; w_be = 3'b010; tick();
    w_en = 0; w_be = 3'b111; r_addr = 3; tick(); tick();
    chk("lane_merge", got_rd[1], 24'h11BB33);
    chk("lane0_off_12b", got_rd[0], 24'h233);

    // Collision at address 7 on the instances without an address register.
    r_addr = 0; w_en = 1; w_addr = 7; w_data = 24'h001; tick();
    r_addr = 7; w_data = 24'h0FF; tick();
    chk("coll_read_old", got_rd[2], 24'h001);
    chk("coll_write_thru", got_rd[3], 24'h0FF);
    chk("coll_busy_m0", {23'h0, bz[2]}, 24'h1);
    chk("coll_busy_m1", {23'h0, bz[3]}, 24'h1);
    chk("comb_new_data", got_rd[4], 24'h0FF);
    w_en = 0; tick();
    chk("coll_busy_clr_m0", {23'h0, bz[2]}, 24'h0);
    chk("coll_busy_clr_m1", {23'h0, bz[3]}, 24'h0);
    chk("after_coll_m0", got_rd[2], 24'h0FF);

    // Out-of-range write on DEPTH=48, and a throttled write.
    w_en = 1; w_addr = 50; w_data = 24'h123456; tick();
    w_en = 0; r_addr = 50; tick(); tick();
    chk("oor_read_zero", got_rd[1], 24'h0);
    chk("addr50_in_range_64", got_rd[0], 24'h456);
    w_en = 1; w_addr = 2; w_data = 24'h777777; tick();
    w_data = 24'h888888; busy_fb = 1; tick();
    w_en = 0; busy_fb = 0; r_addr = 2; tick(); tick();
    chk("busy_fb_blocks", got_rd[1], 24'h777777);

    // Data-register sync load, hold, and block disable.
    r_data_sl_n = 0; r_data_sd = 1; tick();
    chk("sl_ones_12", got_rd[0], 24'hFFF);
    chk("sl_ones_24", got_rd[1], 24'hFFFFFF);
    r_data_sl_n = 1; r_data_en = 0; w_en = 1; w_addr = 2; w_data = 24'h0; tick();
    w_en = 0; tick();
    chk("en_low_holds", got_rd[0], 24'hFFF);
    r_data_en = 1; blk_en = 0; tick();
    chk("blk_en_zero", got_rd[0], 24'h0);
    blk_en = 1;

    // Reset mid-stream, including a write while reset is asserted.
    r_addr = 5; tick(); tick();
    chk("pre_rst_rd5", got_rd[0], 24'hABC);
    set_rst(1'b0);
    #1;
    chk("rst_async_r_data", got_rd[0], 24'h0);
    chk("rst_async_busy", {23'h0, bz[0]}, 24'h0);
    check_all();
    w_en = 1; w_addr = 9; w_data = 24'h5A5; tick();
    w_en = 0; set_rst(1'b1); tick(); tick();
    chk("post_rst_rd5", got_rd[0], 24'hABC);
    r_addr = 9; tick(); tick();
    chk("write_during_rst", got_rd[0], 24'h5A5);

    // Randomized traffic, concentrated on a few addresses to force collisions.
    for (int i = 0; i < 3000; i++) begin
      if (rst_n && $urandom_range(0, 99) == 0)       set_rst(1'b0);
      else if (!rst_n && $urandom_range(0, 2) == 0)  set_rst(1'b1);
      r_addr      = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      w_addr      = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      w_data      = 24'($urandom);
      w_be        = 3'($urandom);
      w_en        = ($urandom_range(0, 1) == 0);
      busy_fb     = ($urandom_range(0, 4) == 0);
      blk_en      = ($urandom_range(0, 7) != 0);
      r_addr_en   = ($urandom_range(0, 3) != 0);
      r_addr_sl_n = ($urandom_range(0, 15) != 0);
      r_addr_sd   = 1'($urandom);
      r_data_en   = ($urandom_range(0, 3) != 0);
      r_data_sl_n = ($urandom_range(0, 15) != 0);
      r_data_sd   = 1'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
